// File: rtl/result_tx.sv
// Sends a 23-byte result frame (sync, argmax class, ten scores, XOR checksum) to the Pi over an 8-bit strobe/ack handshake.
// Each byte costs at least one tick plus two ack edges; a stalled ack edge aborts the frame after TIMEOUT_TICKS ticks.
module result_tx #(
  parameter int TICK_DIV      = 24999,
  parameter int TIMEOUT_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        sc_we,
  input  logic [3:0]  sc_addr,
  input  logic [15:0] sc_din,
  input  logic        start,
  input  logic        rpi_ack,
  output logic [7:0]  gpio_d,
  output logic        fpga_out,
  output logic        busy,
  output logic [3:0]  class_idx,
  output logic        done,
  output logic        err
);

  localparam int TW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam int OW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIV);
  localparam logic [OW-1:0] TO_LAST     = OW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {IDLE, ARGMAX, LOAD, SETUP, STROBE, RELEASE, NEXT, DONE} state_t;
  state_t state, state_nxt;

  logic signed [15:0] score [10];
  logic               ack_m, ack_s;
  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic [OW-1:0]      to_cnt;
  logic               wait_st, to_hit;
  logic [3:0]         arg_i, max_idx, run_idx;
  logic signed [15:0] max_val, run_max;
  logic               upd;
  logic [4:0]         byte_cnt, sc_off;
  logic [3:0]         sc_idx;
  logic [7:0]         chk, sc_byte, cur_byte;
  logic               fpga_out_nxt, busy_nxt, done_nxt, err_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 10; i++) score[i] <= '0;
    end else if (sc_we && sc_addr <= 4'd9 && !busy) begin
      score[sc_addr] <= sc_din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) {ack_s, ack_m} <= 2'b00;
    else       {ack_s, ack_m} <= {ack_m, rpi_ack};
  end

  assign tick    = (tick_cnt == '0);
  assign wait_st = (state == SETUP) || (state == STROBE) || (state == RELEASE);
  assign to_hit  = wait_st && tick && (to_cnt == TO_LAST);

  // Tick phase restarts with each frame so handshake timing is frame-relative.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      if (state == IDLE) begin
        if (state_nxt != IDLE) tick_cnt <= TICK_RELOAD;
      end else if (tick) begin
        tick_cnt <= TICK_RELOAD;
      end else begin
        tick_cnt <= tick_cnt - 1'b1;
      end
      if (!wait_st || state_nxt != state) to_cnt <= '0;
      else if (tick)                      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign run_max = (arg_i == 4'd1) ? score[0] : max_val;
  assign run_idx = (arg_i == 4'd1) ? 4'd0 : max_idx;
  assign upd     = score[arg_i] > run_max;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arg_i     <= 4'd1;
      max_idx   <= '0;
      max_val   <= '0;
      class_idx <= '0;
    end else if (state == IDLE) begin
      arg_i <= 4'd1;
    end else if (state == ARGMAX) begin
      arg_i   <= arg_i + 4'd1;
      max_val <= upd ? score[arg_i] : run_max;
      max_idx <= upd ? arg_i : run_idx;
      if (arg_i == 4'd9) class_idx <= upd ? arg_i : run_idx;
    end
  end

  // Bytes 2..21 walk the scores high byte first.
  assign sc_off  = byte_cnt - 5'd2;
  assign sc_idx  = (byte_cnt >= 5'd2 && byte_cnt <= 5'd21) ? sc_off[4:1] : 4'd0;
  assign sc_byte = sc_off[0] ? score[sc_idx][7:0] : score[sc_idx][15:8];

  always_comb begin
    cur_byte = sc_byte;
    case (byte_cnt)
      5'd0:    cur_byte = 8'hA5;
      5'd1:    cur_byte = {4'h0, class_idx};
      5'd22:   cur_byte = chk;
      default: cur_byte = sc_byte;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gpio_d   <= '0;
      byte_cnt <= '0;
      chk      <= '0;
    end else begin
      if (!en)                gpio_d <= '0;
      else if (state == LOAD) gpio_d <= cur_byte;
      if (state == IDLE) begin
        byte_cnt <= '0;
        chk      <= '0;
      end else if (state == LOAD && byte_cnt != 5'd22) begin
        chk <= chk ^ cur_byte;
      end else if (state == NEXT) begin
        byte_cnt <= byte_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      fpga_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      fpga_out <= fpga_out_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARGMAX;
      ARGMAX:  if (arg_i == 4'd9) state_nxt = LOAD;
      LOAD:    state_nxt = SETUP;
      SETUP:   if (tick && !ack_s) state_nxt = STROBE;
               else if (to_hit)   state_nxt = IDLE;
      STROBE:  if (ack_s)         state_nxt = RELEASE;
               else if (to_hit)   state_nxt = IDLE;
      RELEASE: if (!ack_s)        state_nxt = NEXT;
               else if (to_hit)   state_nxt = IDLE;
      NEXT:    state_nxt = (byte_cnt == 5'd22) ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!en) state_nxt = IDLE;
  end

  // Outputs are registered from the next state so the Pi never sees decode glitches.
  always_comb begin
    fpga_out_nxt = (state_nxt == STROBE);
    busy_nxt     = (state_nxt != IDLE);
    done_nxt     = (state_nxt == DONE);
    err_nxt      = en && wait_st && (state_nxt == IDLE);
  end

endmodule

// File: tb/tb_result_tx.sv
// Directed bench for result_tx: frame contents, argmax corner cases, timeout, ignored requests, reset and enable drop.
module tb_result_tx;
  localparam int TD = 3;
  localparam int TO = 5;
  localparam logic [7:0] EXP_BASIC [23] = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                            8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA7};
  localparam logic [7:0] EXP_EN [23]    = '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00,
                                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB0};

  logic        clk = 1'b0;
  logic        rstn, en, sc_we, start;
  logic        rpi_ack = 1'b0;
  logic [3:0]  sc_addr;
  logic [15:0] sc_din;
  logic [7:0]  gpio_d;
  logic        fpga_out, busy, done, err;
  logic [3:0]  class_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int strobe_cnt = 0;
  logic [7:0] cap [256];
  logic fo_prev = 1'b0;
  logic pi_on = 1'b1;

  result_tx #(.TICK_DIV(TD), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rstn(rstn), .en(en), .sc_we(sc_we), .sc_addr(sc_addr), .sc_din(sc_din),
    .start(start), .rpi_ack(rpi_ack), .gpio_d(gpio_d), .fpga_out(fpga_out), .busy(busy),
    .class_idx(class_idx), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Pi model: captures gpio_d on each strobe rising edge and mirrors the strobe as ack.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (fpga_out && !fo_prev) begin
      cap[strobe_cnt % 256] = gpio_d;
      strobe_cnt++;
    end
    fo_prev = fpga_out;
    rpi_ack = pi_on & fpga_out;
  end

  task step;
    @(negedge clk);
    #1;
  endtask

  task write_score(input logic [3:0] a, input logic [15:0] d);
    sc_we = 1'b1; sc_addr = a; sc_din = d;
    step;
    sc_we = 1'b0;
  endtask

  task pulse_start;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask

  task wait_idle(input int budget, output logic ok);
    int i;
    i = 0;
    while (busy && i < budget) begin step; i++; end
    ok = !busy;
  endtask

  task wait_strobes(input int target, input int budget, output logic ok);
    int i;
    i = 0;
    while (strobe_cnt < target && i < budget) begin step; i++; end
    ok = (strobe_cnt >= target);
  endtask

  task test_reset;
    rstn = 1'b0; en = 1'b1; sc_we = 1'b0; sc_addr = '0; sc_din = '0; start = 1'b0;
    repeat (3) step;
    n_cmp++; if (gpio_d !== 8'h00)   begin n_bad++; $display("FAIL reset_gpio_d got %h want 00", gpio_d); end
    n_cmp++; if (fpga_out !== 1'b0)  begin n_bad++; $display("FAIL reset_fpga_out got %b want 0", fpga_out); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (class_idx !== 4'd0) begin n_bad++; $display("FAIL reset_class_idx got %0d want 0", class_idx); end
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    rstn = 1'b1;
    step;
  endtask

  task test_basic_frame;
    int base, d0, e0;
    logic ok;
    for (int i = 0; i < 10; i++) write_score(4'(i), (i == 3) ? 16'h0100 : 16'h0000);
    base = strobe_cnt; d0 = done_cnt; e0 = err_cnt;
    pulse_start;
    wait_idle(2000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_complete got busy=%b want frame end", busy); end
    n_cmp++; if (strobe_cnt - base != 23) begin n_bad++; $display("FAIL basic_count got %0d want 23", strobe_cnt - base); end
    for (int k = 0; k < 23; k++) begin
      n_cmp++;
      if (cap[(base + k) % 256] !== EXP_BASIC[k]) begin
        n_bad++; $display("FAIL basic_byte%0d got %h want %h", k, cap[(base + k) % 256], EXP_BASIC[k]);
      end
    end
    n_cmp++; if (class_idx !== 4'd3) begin n_bad++; $display("FAIL basic_class got %0d want 3", class_idx); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL basic_done got %0d want 1", done_cnt - d0); end
    n_cmp++; if (err_cnt - e0 != 0)  begin n_bad++; $display("FAIL basic_err got %0d want 0", err_cnt - e0); end
  endtask

  task test_signed;
    int base;
    logic ok;
    for (int i = 0; i < 10; i++) write_score(4'(i), (i == 2 || i == 7) ? 16'h7FFF : 16'h8000);
    base = strobe_cnt;
    pulse_start;
    wait_idle(2000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL signed_complete got busy=%b want frame end", busy); end
    n_cmp++; if (class_idx !== 4'd2) begin n_bad++; $display("FAIL signed_class got %0d want 2", class_idx); end
    n_cmp++; if (cap[(base + 6) % 256] !== 8'h7F) begin n_bad++; $display("FAIL signed_byte6 got %h want 7f", cap[(base + 6) % 256]); end
    n_cmp++; if (cap[(base + 22) % 256] !== 8'hA7) begin n_bad++; $display("FAIL signed_chk got %h want a7", cap[(base + 22) % 256]); end
  endtask

  task test_tie;
    int base;
    logic ok;
    for (int i = 0; i < 10; i++) write_score(4'(i), (i == 9) ? 16'hFFFE : 16'hFFFF);
    base = strobe_cnt;
    pulse_start;
    wait_idle(2000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL tie_complete got busy=%b want frame end", busy); end
    n_cmp++; if (class_idx !== 4'd0) begin n_bad++; $display("FAIL tie_class got %0d want 0", class_idx); end
    n_cmp++; if (cap[(base + 21) % 256] !== 8'hFE) begin n_bad++; $display("FAIL tie_byte21 got %h want fe", cap[(base + 21) % 256]); end
    n_cmp++; if (cap[(base + 22) % 256] !== 8'hA4) begin n_bad++; $display("FAIL tie_chk got %h want a4", cap[(base + 22) % 256]); end
  endtask

  task test_timeout;
    int d0, e0, cnt, i;
    pi_on = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    pulse_start;
    i = 0;
    while (!fpga_out && i < 200) begin step; i++; end
    n_cmp++; if (fpga_out !== 1'b1) begin n_bad++; $display("FAIL timeout_strobe got %b want 1", fpga_out); end
    cnt = 0;
    while (fpga_out && cnt < 500) begin cnt++; step; end
    n_cmp++; if (cnt != TO * (TD + 1)) begin n_bad++; $display("FAIL timeout_len got %0d want %0d", cnt, TO * (TD + 1)); end
    n_cmp++; if (err !== 1'b1)  begin n_bad++; $display("FAIL timeout_err got %b want 1", err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy got %b want 0", busy); end
    repeat (5) step;
    n_cmp++; if (err_cnt - e0 != 1)  begin n_bad++; $display("FAIL timeout_err_pulses got %0d want 1", err_cnt - e0); end
    n_cmp++; if (done_cnt - d0 != 0) begin n_bad++; $display("FAIL timeout_done got %0d want 0", done_cnt - d0); end
    pi_on = 1'b1;
    repeat (5) step;
  endtask

  task test_ignore_and_reset;
    int base, d0, s;
    logic ok;
    for (int i = 0; i < 10; i++) write_score(4'(i), (i == 3) ? 16'h0100 : 16'h0000);
    base = strobe_cnt; d0 = done_cnt;
    pulse_start;
    wait_strobes(base + 5, 1000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ignore_reach5 got %0d want %0d", strobe_cnt - base, 5); end
    pulse_start;
    write_score(4'd3, 16'h7777);
    wait_idle(2000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ignore_complete got busy=%b want frame end", busy); end
    for (int k = 0; k < 23; k++) begin
      n_cmp++;
      if (cap[(base + k) % 256] !== EXP_BASIC[k]) begin
        n_bad++; $display("FAIL ignore_byte%0d got %h want %h", k, cap[(base + k) % 256], EXP_BASIC[k]);
      end
    end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL ignore_done got %0d want 1", done_cnt - d0); end
    repeat (50) step;
    n_cmp++; if (strobe_cnt - base != 23) begin n_bad++; $display("FAIL ignore_no_restart got %0d want 23", strobe_cnt - base); end

    base = strobe_cnt;
    pulse_start;
    wait_strobes(base + 10, 1000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_reach10 got %0d want 10", strobe_cnt - base); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (fpga_out !== 1'b0)  begin n_bad++; $display("FAIL rst_fpga_out got %b want 0", fpga_out); end
    n_cmp++; if (gpio_d !== 8'h00)   begin n_bad++; $display("FAIL rst_gpio_d got %h want 00", gpio_d); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (class_idx !== 4'd0) begin n_bad++; $display("FAIL rst_class got %0d want 0", class_idx); end
    n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_pulses got done=%b err=%b want 0 0", done, err); end
    repeat (3) step;
    rstn = 1'b1;
    s = strobe_cnt;
    repeat (50) step;
    n_cmp++; if (strobe_cnt != s) begin n_bad++; $display("FAIL rst_no_strobe got %0d want 0", strobe_cnt - s); end
  endtask

  task test_en_drop;
    int base, d0;
    logic ok;
    write_score(4'd5, 16'h0010);
    base = strobe_cnt;
    pulse_start;
    wait_strobes(base + 12, 1000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL en_reach12 got %0d want 12", strobe_cnt - base); end
    en = 1'b0;
    step;
    n_cmp++; if (fpga_out !== 1'b0)  begin n_bad++; $display("FAIL en_fpga_out got %b want 0", fpga_out); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL en_busy got %b want 0", busy); end
    n_cmp++; if (gpio_d !== 8'h00)   begin n_bad++; $display("FAIL en_gpio_d got %h want 00", gpio_d); end
    n_cmp++; if (class_idx !== 4'd5) begin n_bad++; $display("FAIL en_class got %0d want 5", class_idx); end
    en = 1'b1;
    repeat (5) step;
    base = strobe_cnt; d0 = done_cnt;
    pulse_start;
    wait_idle(2000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL en_complete got busy=%b want frame end", busy); end
    n_cmp++; if (strobe_cnt - base != 23) begin n_bad++; $display("FAIL en_count got %0d want 23", strobe_cnt - base); end
    for (int k = 0; k < 23; k++) begin
      n_cmp++;
      if (cap[(base + k) % 256] !== EXP_EN[k]) begin
        n_bad++; $display("FAIL en_byte%0d got %h want %h", k, cap[(base + k) % 256], EXP_EN[k]);
      end
    end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL en_done got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_signed;
    test_tie;
    test_timeout;
    test_ignore_and_reset;
    test_en_drop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/result_tx.md
RESULT_TX -- requirements
Module: result_tx

Interface
REQ-001 SHALL have parameter TICK_DIV, default 24999; the handshake tick fires once every TICK_DIV+1 clk cycles.
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 1000; this is the maximum number of ticks spent waiting on any single rpi_ack edge.
REQ-003 SHALL have ports as follows:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- en  in  1  block enable.
- sc_we  in  1  score write strobe.
- sc_addr  in  4  score index, 0..9.
- sc_din  in  16  signed score value.
- start  in  1  one-cycle transmit request.
- rpi_ack  in  1  asynchronous acknowledge from the Pi.
- gpio_d  out  8  byte presented to the Pi.
- fpga_out  out  1  byte strobe to the Pi.
- busy  out  1  frame in progress.
- class_idx  out  4  argmax result.
- done  out  1  one-cycle pulse at frame end.
- err  out  1  one-cycle pulse on timeout.

Function
REQ-004 SHALL hold 10 x 16-bit score registers; sc_we with sc_addr<=9 and busy=0 writes sc_din; writes with sc_addr>9 or busy=1 are ignored.
REQ-005 SHALL pass rpi_ack through a 2-flop synchronizer (ack_s); all handshake decisions use ack_s only.
REQ-006 SHALL run a tick counter only while busy=1; the counter reloads to TICK_DIV on leaving IDLE.
REQ-007 SHALL implement the FSM states IDLE, ARGMAX, LOAD, SETUP, STROBE, RELEASE, NEXT, DONE.
REQ-008 IDLE: start=1 with en=1 SHALL go to ARGMAX and set busy=1; start while busy=1 SHALL be ignored.
REQ-009 ARGMAX SHALL compare scores 1..9 against the running maximum, one per clk cycle (9 cycles total), using signed compare; ties SHALL keep the lower index; class_idx SHALL update on completion and hold until the next ARGMAX.
REQ-010 The frame SHALL be 23 bytes, in this order:
- 0xA5.
- {4'h0, class_idx}.
- score0..score9, MSB byte first.
- XOR checksum of the 22 preceding bytes.
REQ-011 LOAD SHALL drive the current frame byte on gpio_d, which stays stable until NEXT.
REQ-012 SETUP SHALL wait one tick with fpga_out=0, then go to STROBE.
REQ-013 STROBE SHALL drive fpga_out=1 and wait for ack_s=1, then go to RELEASE.
REQ-014 RELEASE SHALL drive fpga_out=0 and wait for ack_s=0, then go to NEXT.
REQ-015 NEXT SHALL increment a 5-bit byte counter; the counter reaching 23 SHALL go to DONE, otherwise to LOAD.
REQ-016 DONE SHALL pulse done for 1 cycle, clear busy, and return to IDLE.
REQ-017 Every wait in STROBE or RELEASE SHALL count ticks; reaching TIMEOUT_TICKS SHALL pulse err for 1 cycle, force fpga_out=0, clear busy, and return to IDLE without pulsing done.
REQ-018 ack_s=1 on entry to SETUP (stale ack) SHALL hold SETUP until ack_s=0, subject to the timeout in REQ-017.
REQ-019 en=0 SHALL synchronously force IDLE with gpio_d=0, fpga_out=0, busy=0; score registers and class_idx SHALL be kept.
REQ-020 The checksum SHALL accumulate as each byte is loaded; the final byte SHALL equal the accumulated XOR.

Reset
REQ-021 rstn=0 SHALL asynchronously set:
- state=IDLE.
- gpio_d=0, fpga_out=0, busy=0, class_idx=0, done=0, err=0.
- scores=0.
- tick, byte and timeout counters=0.
- synchronizer flops=0.
REQ-022 Reset asserted mid-frame SHALL drop fpga_out within the same cycle, and the Pi side SHALL see no further strobes.

Verification
REQ-023 Scores all 0 except score3=0x0100, start, Pi model acks each byte -> class_idx=3; bytes A5,03,00,00,00,00,00,00,01,00, then 12x00, then A7; done pulses once.
REQ-024 score2=score7=0x7FFF, others 0x8000 -> class_idx=2; byte 6 = 0x7F.
REQ-025 All scores 0xFFFF except score9=0xFFFE -> class_idx=0 (tie broken to the lowest index).
REQ-026 Pi model never raises ack -> fpga_out=1 for TIMEOUT_TICKS ticks, then err pulses, fpga_out=0, busy=0, and done is never asserted.
REQ-027 start asserted again at byte 5 and sc_we issued mid-frame -> both are ignored; frame completes unchanged; rstn pulsed at byte 10 -> all outputs 0 immediately.
REQ-028 en deasserted at byte 12 -> IDLE next cycle with fpga_out=0; class_idx is retained; a new start sends a full 23-byte frame.
